in_decode: RTL and testbench

RV32I instruction-decode stage of the 5-stage riscv_core pipeline, sitting between InFetch and Execute. It contains:
- the 32x32 register file,
- the main control unit,
- the immediate generator,
- the ID/EX pipeline register.

Write-back drives the register-file write port. All decoded fields, operands and control bits are registered and presented to Execute one cycle later.

---
 rtl/riscv_pkg.sv | 75 +++++++
 rtl/in_decode_if.sv | 55 +++++
 rtl/reg_file.sv | 57 +++++
 rtl/in_decode.sv | 168 ++++++++++++++++
 tb/tb_in_decode.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared RV32I decode constants, control and ID/EX types
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       lui;
    imm_fmt_e   imm_fmt;
  } ctrl_t;

  typedef struct packed {
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic [1:0]      alu_op;
    logic            jal;
    logic            jalr;
    logic            auipc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
  } idex_t;

endpackage

`default_nettype wire

// File: rtl/in_decode_if.sv
// ---------------------------------------------------------------------------
// in_decode_if : IF/ID + write-back inputs and ID/EX outputs of the decode stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface in_decode_if;
  import riscv_pkg::*;

  logic            Ctl_RegWrite_in;
  logic [4:0]      WriteReg;
  logic [XLEN-1:0] WriteData;
  logic [XLEN-1:0] PC_in;
  logic [XLEN-1:0] instruction_in;

  logic            Ctl_ALUSrc_out;
  logic            Ctl_MemtoReg_out;
  logic            Ctl_RegWrite_out;
  logic            Ctl_MemRead_out;
  logic            Ctl_MemWrite_out;
  logic            Ctl_Branch_out;
  logic            Ctl_ALUOpcode1_out;
  logic            Ctl_ALUOpcode0_out;
  logic [4:0]      Rd_out;
  logic [4:0]      Rs1_out;
  logic [4:0]      Rs2_out;
  logic [XLEN-1:0] PC_out;
  logic [XLEN-1:0] ReadData1_out;
  logic [XLEN-1:0] ReadData2_out;
  logic [XLEN-1:0] Immediate_out;
  logic [6:0]      funct7_out;
  logic [2:0]      funct3_out;
  logic            jalr_out;
  logic            jal_out;
  logic            auipc_out;

  modport master (
    output Ctl_RegWrite_in, WriteReg, WriteData, PC_in, instruction_in,
    input  Ctl_ALUSrc_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
           Ctl_MemWrite_out, Ctl_Branch_out, Ctl_ALUOpcode1_out, Ctl_ALUOpcode0_out,
           Rd_out, Rs1_out, Rs2_out, PC_out, ReadData1_out, ReadData2_out,
           Immediate_out, funct7_out, funct3_out, jalr_out, jal_out, auipc_out
  );

  modport slave (
    input  Ctl_RegWrite_in, WriteReg, WriteData, PC_in, instruction_in,
    output Ctl_ALUSrc_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
           Ctl_MemWrite_out, Ctl_Branch_out, Ctl_ALUOpcode1_out, Ctl_ALUOpcode0_out,
           Rd_out, Rs1_out, Rs2_out, PC_out, ReadData1_out, ReadData2_out,
           Immediate_out, funct7_out, funct3_out, jalr_out, jal_out, auipc_out
  );

endinterface

`default_nettype wire

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file : 32x32 register file, x0 hard-wired to zero, write-through reads
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file
  import riscv_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            wr_en,
  input  wire logic [4:0]      wr_addr,
  input  wire logic [XLEN-1:0] wr_data,
  input  wire logic [4:0]      rd_addr1,
  input  wire logic [4:0]      rd_addr2,
  output logic      [XLEN-1:0] rd_data1,
  output logic      [XLEN-1:0] rd_data2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_active;

  assign wr_active = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A same-cycle write to the register being read wins over the stored value.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == 5'd0) begin
      rd_data1 = '0;
    end else if (wr_active && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == 5'd0) begin
      rd_data2 = '0;
    end else if (wr_active && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/in_decode.sv
// ---------------------------------------------------------------------------
// in_decode : RV32I decode stage - register file, control, immediates, ID/EX register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module in_decode
  import riscv_pkg::*;
(
  input wire logic clk,
  input wire logic reset,
  in_decode_if.slave bus
);

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1_addr;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  idex_t           idex_d;
  idex_t           idex_q;

  assign instr  = bus.instruction_in;
  assign opcode = instr[6:0];

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_R;
      end
      OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_IMM;
        ctrl.imm_fmt   = IMM_I;
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.imm_fmt    = IMM_I;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.imm_fmt   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_BRANCH;
        ctrl.imm_fmt = IMM_B;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.imm_fmt   = IMM_J;
      end
      OP_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.imm_fmt   = IMM_I;
      end
      OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.auipc     = 1'b1;
        ctrl.imm_fmt   = IMM_U;
      end
      OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.lui       = 1'b1;
        ctrl.imm_fmt   = IMM_U;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    imm = '0;
    case (ctrl.imm_fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // lui has no rs1; its field bits belong to the immediate, so read x0 instead.
  assign rs1_addr = ctrl.lui ? 5'd0 : instr[19:15];

  reg_file u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.Ctl_RegWrite_in),
    .wr_addr  (bus.WriteReg),
    .wr_data  (bus.WriteData),
    .rd_addr1 (rs1_addr),
    .rd_addr2 (instr[24:20]),
    .rd_data1 (rdata1),
    .rd_data2 (rdata2)
  );

  always_comb begin
    idex_d            = '0;
    idex_d.alu_src    = ctrl.alu_src;
    idex_d.mem_to_reg = ctrl.mem_to_reg;
    idex_d.reg_write  = ctrl.reg_write;
    idex_d.mem_read   = ctrl.mem_read;
    idex_d.mem_write  = ctrl.mem_write;
    idex_d.branch     = ctrl.branch;
    idex_d.alu_op     = ctrl.alu_op;
    idex_d.jal        = ctrl.jal;
    idex_d.jalr       = ctrl.jalr;
    idex_d.auipc      = ctrl.auipc;
    idex_d.rd         = instr[11:7];
    idex_d.rs1        = rs1_addr;
    idex_d.rs2        = instr[24:20];
    idex_d.pc         = bus.PC_in;
    idex_d.rdata1     = rdata1;
    idex_d.rdata2     = rdata2;
    idex_d.imm        = imm;
    idex_d.funct7     = instr[31:25];
    idex_d.funct3     = instr[14:12];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.Ctl_ALUSrc_out     = idex_q.alu_src;
  assign bus.Ctl_MemtoReg_out   = idex_q.mem_to_reg;
  assign bus.Ctl_RegWrite_out   = idex_q.reg_write;
  assign bus.Ctl_MemRead_out    = idex_q.mem_read;
  assign bus.Ctl_MemWrite_out   = idex_q.mem_write;
  assign bus.Ctl_Branch_out     = idex_q.branch;
  assign bus.Ctl_ALUOpcode1_out = idex_q.alu_op[1];
  assign bus.Ctl_ALUOpcode0_out = idex_q.alu_op[0];
  assign bus.Rd_out             = idex_q.rd;
  assign bus.Rs1_out            = idex_q.rs1;
  assign bus.Rs2_out            = idex_q.rs2;
  assign bus.PC_out             = idex_q.pc;
  assign bus.ReadData1_out      = idex_q.rdata1;
  assign bus.ReadData2_out      = idex_q.rdata2;
  assign bus.Immediate_out      = idex_q.imm;
  assign bus.funct7_out         = idex_q.funct7;
  assign bus.funct3_out         = idex_q.funct3;
  assign bus.jalr_out           = idex_q.jalr;
  assign bus.jal_out            = idex_q.jal;
  assign bus.auipc_out          = idex_q.auipc;

endmodule

`default_nettype wire

// File: tb/tb_in_decode.sv
// ---------------------------------------------------------------------------
// tb_in_decode : directed and randomized checks of in_decode against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_in_decode;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  in_decode_if bus ();

  in_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Row layout: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0],jal,jalr,auipc}
  function automatic logic [10:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'b0110011: return 11'b001000_10_000;
      7'b0010011: return 11'b101000_11_000;
      7'b0000011: return 11'b111100_00_000;
      7'b0100011: return 11'b100010_00_000;
      7'b1100011: return 11'b000001_01_000;
      7'b1101111: return 11'b001000_00_100;
      7'b1100111: return 11'b101000_00_010;
      7'b0010111: return 11'b101000_00_001;
      7'b0110111: return 11'b101000_00_000;
      default:    return 11'b000000_00_000;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    v = 0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        v = int'($signed(ins[31:20]));
      7'b0100011:
        v = int'($signed({ins[31:25], ins[11:7]}));
      7'b1100011:
        v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
            + int'(ins[11:8]) * 2;
      7'b0110111, 7'b0010111:
        v = int'(ins & 32'hFFFF_F000);
      7'b1101111:
        v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wr == r) return wd;
    return mregs[r];
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_alusrc"},  32'(bus.Ctl_ALUSrc_out), 0);
    chk({pfx, "_memtoreg"},32'(bus.Ctl_MemtoReg_out), 0);
    chk({pfx, "_regwrite"},32'(bus.Ctl_RegWrite_out), 0);
    chk({pfx, "_memread"}, 32'(bus.Ctl_MemRead_out), 0);
    chk({pfx, "_memwrite"},32'(bus.Ctl_MemWrite_out), 0);
    chk({pfx, "_branch"},  32'(bus.Ctl_Branch_out), 0);
    chk({pfx, "_aluop"},   32'({bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out}), 0);
    chk({pfx, "_rd"},      32'(bus.Rd_out), 0);
    chk({pfx, "_rs1"},     32'(bus.Rs1_out), 0);
    chk({pfx, "_rs2"},     32'(bus.Rs2_out), 0);
    chk({pfx, "_pc"},      bus.PC_out, 0);
    chk({pfx, "_rdata1"},  bus.ReadData1_out, 0);
    chk({pfx, "_rdata2"},  bus.ReadData2_out, 0);
    chk({pfx, "_imm"},     bus.Immediate_out, 0);
    chk({pfx, "_funct7"},  32'(bus.funct7_out), 0);
    chk({pfx, "_funct3"},  32'(bus.funct3_out), 0);
    chk({pfx, "_flags"},   32'({bus.jal_out, bus.jalr_out, bus.auipc_out}), 0);
  endtask

  // Present one instruction (plus an optional write-back), clock it, check every output.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd);
    logic [10:0] c;
    logic [4:0]  rs1;
    logic [31:0] e_imm, e_rd1, e_rd2;
    c     = ref_ctrl(ins[6:0]);
    rs1   = (ins[6:0] == 7'b0110111) ? 5'd0 : ins[19:15];
    e_imm = ref_imm(ins);
    e_rd1 = ref_read(rs1, we, wr, wd);
    e_rd2 = ref_read(ins[24:20], we, wr, wd);
    bus.instruction_in  = ins;
    bus.PC_in           = pc;
    bus.Ctl_RegWrite_in = we;
    bus.WriteReg        = wr;
    bus.WriteData       = wd;
    @(posedge clk);
    #1;
    chk("alusrc",   32'(bus.Ctl_ALUSrc_out),   32'(c[10]));
    chk("memtoreg", 32'(bus.Ctl_MemtoReg_out), 32'(c[9]));
    chk("regwrite", 32'(bus.Ctl_RegWrite_out), 32'(c[8]));
    chk("memread",  32'(bus.Ctl_MemRead_out),  32'(c[7]));
    chk("memwrite", 32'(bus.Ctl_MemWrite_out), 32'(c[6]));
    chk("branch",   32'(bus.Ctl_Branch_out),   32'(c[5]));
    chk("aluop",    32'({bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out}), 32'(c[4:3]));
    chk("jal",      32'(bus.jal_out),   32'(c[2]));
    chk("jalr",     32'(bus.jalr_out),  32'(c[1]));
    chk("auipc",    32'(bus.auipc_out), 32'(c[0]));
    chk("rd",       32'(bus.Rd_out),  32'(ins[11:7]));
    chk("rs1",      32'(bus.Rs1_out), 32'(rs1));
    chk("rs2",      32'(bus.Rs2_out), 32'(ins[24:20]));
    chk("pc",       bus.PC_out, pc);
    chk("rdata1",   bus.ReadData1_out, e_rd1);
    chk("rdata2",   bus.ReadData2_out, e_rd2);
    chk("imm",      bus.Immediate_out, e_imm);
    chk("funct7",   32'(bus.funct7_out), 32'(ins[31:25]));
    chk("funct3",   32'(bus.funct3_out), 32'(ins[14:12]));
    if (we && wr != 5'd0) mregs[wr] = wd;
  endtask

  logic [6:0] ops [13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111,
                           7'h7F, 7'h0F, 7'h73, 7'h00};

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    reset               = 1'b0;
    bus.instruction_in  = 32'h0061A783;
    bus.PC_in           = 32'h0000_0044;
    bus.Ctl_RegWrite_in = 1'b1;
    bus.WriteReg        = 5'd3;
    bus.WriteData       = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Fresh register file reads zero everywhere.
    step(32'h00208533, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("post_reset_rd1", bus.ReadData1_out, 32'd0);

    for (int k = 1; k <= 15; k++) begin
      step(32'h00000013, 32'd0, 1'b1, 5'(k), 32'(k + 2));
    end

    step(32'h00208533, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("add_rd1", bus.ReadData1_out, 32'd3);
    chk("add_rd2", bus.ReadData2_out, 32'd4);
    chk("add_rd",  32'(bus.Rd_out), 32'd10);
    chk("add_regwrite", 32'(bus.Ctl_RegWrite_out), 32'd1);
    chk("add_alusrc", 32'(bus.Ctl_ALUSrc_out), 32'd0);
    chk("add_aluop", 32'({bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out}), 32'd2);
    chk("add_imm", bus.Immediate_out, 32'd0);

    step(32'h40A58633, 32'd4, 1'b0, 5'd0, 32'd0);
    chk("sub_rd1", bus.ReadData1_out, 32'd13);
    chk("sub_rd2", bus.ReadData2_out, 32'd12);
    chk("sub_funct7", 32'(bus.funct7_out), 32'h20);

    step(32'h00400513, 32'd8, 1'b0, 5'd0, 32'd0);
    chk("addi_imm", bus.Immediate_out, 32'd4);
    chk("addi_rd1", bus.ReadData1_out, 32'd0);
    chk("addi_alusrc", 32'(bus.Ctl_ALUSrc_out), 32'd1);
    chk("addi_aluop", 32'({bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out}), 32'd3);

    step(32'h0061A783, 32'd12, 1'b0, 5'd0, 32'd0);
    chk("lw_imm", bus.Immediate_out, 32'd6);
    chk("lw_rd1", bus.ReadData1_out, 32'd5);
    chk("lw_memread", 32'(bus.Ctl_MemRead_out), 32'd1);
    chk("lw_memtoreg", 32'(bus.Ctl_MemtoReg_out), 32'd1);
    chk("lw_funct3", 32'(bus.funct3_out), 32'd2);

    step(32'h00C024A3, 32'd16, 1'b0, 5'd0, 32'd0);
    chk("sw_imm", bus.Immediate_out, 32'd9);
    chk("sw_rd2", bus.ReadData2_out, 32'd14);
    chk("sw_memwrite", 32'(bus.Ctl_MemWrite_out), 32'd1);
    chk("sw_regwrite", 32'(bus.Ctl_RegWrite_out), 32'd0);

    step(32'h00429463, 32'd20, 1'b0, 5'd0, 32'd0);
    chk("bne_imm", bus.Immediate_out, 32'd8);
    chk("bne_rd1", bus.ReadData1_out, 32'd7);
    chk("bne_rd2", bus.ReadData2_out, 32'd6);
    chk("bne_branch", 32'(bus.Ctl_Branch_out), 32'd1);
    chk("bne_aluop", 32'({bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out}), 32'd1);
    chk("bne_funct3", 32'(bus.funct3_out), 32'd1);
    chk("bne_pc", bus.PC_out, 32'd20);

    step(32'h000001B3, 32'd24, 1'b1, 5'd0, 32'hDEAD_BEEF);
    chk("x0_wr_same", bus.ReadData1_out, 32'd0);
    step(32'h000001B3, 32'd28, 1'b0, 5'd0, 32'd0);
    chk("x0_wr_after", bus.ReadData1_out, 32'd0);

    step(32'h00528333, 32'd32, 1'b1, 5'd5, 32'h0000_ABCD);
    chk("bypass_rd1", bus.ReadData1_out, 32'h0000_ABCD);
    chk("bypass_rd2", bus.ReadData2_out, 32'h0000_ABCD);
    step(32'h00528333, 32'd36, 1'b0, 5'd0, 32'd0);

    step(32'hFFDFF0EF, 32'd40, 1'b0, 5'd0, 32'd0);
    chk("jal_imm", bus.Immediate_out, 32'hFFFF_FFFC);
    chk("jal_flag", 32'(bus.jal_out), 32'd1);

    step(32'h123452B7, 32'd44, 1'b0, 5'd0, 32'd0);
    chk("lui_imm", bus.Immediate_out, 32'h1234_5000);
    chk("lui_rd1", bus.ReadData1_out, 32'd0);
    chk("lui_rs1", 32'(bus.Rs1_out), 32'd0);

    step(32'h0020807F, 32'd48, 1'b0, 5'd0, 32'd0);
    chk("unk_ctrl", 32'({bus.Ctl_ALUSrc_out, bus.Ctl_MemtoReg_out, bus.Ctl_RegWrite_out,
                         bus.Ctl_MemRead_out, bus.Ctl_MemWrite_out, bus.Ctl_Branch_out,
                         bus.Ctl_ALUOpcode1_out, bus.Ctl_ALUOpcode0_out,
                         bus.jal_out, bus.jalr_out, bus.auipc_out}), 32'd0);
    chk("unk_imm", bus.Immediate_out, 32'd0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      step({r[31:7], ops[$urandom_range(0, 12)]}, $urandom(), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom());
    end

    // Asynchronous reset mid-cycle clears the pipeline register and the register file.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    step(32'h00528333, 32'd52, 1'b0, 5'd0, 32'd0);
    chk("cleared_x5", bus.ReadData1_out, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
